param_stack: RTL and testbench

PARAM_STACK -- requirements
Module: param_stack

---
 rtl/param_stack_if.sv | 37 +++
 rtl/param_stack.sv | 131 +++++++++++++
 tb/tb_param_stack.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/param_stack_if.sv
// param_stack_if -- request/status bundle for param_stack.
//   master : drives CS, Push, Pop, Data_In, Clr_Err; observes the rest.
//   slave  : the stack itself.
//   Data_Out/Valid : registered popped word plus a one-cycle pulse when it updates.
//   Top            : combinational peek of the top entry (0 when empty).
//   Count          : occupancy 0..2^ADDR_DEPTH.
//   Full/Empty/Almost_Full : occupancy flags, derived from Count.
//   Overflow/Underflow     : sticky error flags.
interface param_stack_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_DEPTH = 4
);
  logic                  CS;
  logic                  Push;
  logic                  Pop;
  logic [DATA_WIDTH-1:0] Data_In;
  logic                  Clr_Err;
  logic [DATA_WIDTH-1:0] Data_Out;
  logic                  Valid;
  logic [DATA_WIDTH-1:0] Top;
  logic [ADDR_DEPTH:0]   Count;
  logic                  Full;
  logic                  Empty;
  logic                  Almost_Full;
  logic                  Overflow;
  logic                  Underflow;

  modport master (
    output CS, Push, Pop, Data_In, Clr_Err,
    input  Data_Out, Valid, Top, Count, Full, Empty, Almost_Full, Overflow, Underflow
  );

  modport slave (
    input  CS, Push, Pop, Data_In, Clr_Err,
    output Data_Out, Valid, Top, Count, Full, Empty, Almost_Full, Overflow, Underflow
  );
endinterface

// File: rtl/param_stack.sv
// param_stack -- LIFO stack of 2^ADDR_DEPTH words of DATA_WIDTH bits.
//   clk   : single clock, rising edge.
//   rst   : asynchronous, active-low reset (clears Count, Data_Out, Valid, error flags;
//           memory contents are left alone).
//   bus   : param_stack_if.slave -- requests in, popped data/occupancy/flags out.
// Push+Pop together replaces the top entry (or bypasses Data_In when empty).
// Optional feature: define PARAM_STACK_ERR_FLAGS_EN for sticky Overflow/Underflow
// flags cleared by Clr_Err; otherwise both flags are tied 0.
module param_stack #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_DEPTH      = 4,
  parameter int ALMOST_FULL_LVL = 14
) (
  input  logic           clk,
  input  logic           rst,
  param_stack_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_DEPTH;
  localparam int CW    = ADDR_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LVL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  wr_en;
  logic [ADDR_DEPTH-1:0] wr_idx, top_idx;
  logic                  push_v, pop_v, full, empty;
  logic                  ovf_ev, unf_ev;

  assign push_v = bus.CS & bus.Push;
  assign pop_v  = bus.CS & bus.Pop;
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  // Low bits minus one: at Count == DEPTH the low bits are 0 and this wraps to
  // DEPTH-1, which is exactly the top slot. Only used when not empty.
  assign top_idx = count_q[ADDR_DEPTH-1:0] - 1'b1;

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = count_q[ADDR_DEPTH-1:0];
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    case ({push_v, pop_v})
      2'b11: begin
        valid_d = 1'b1;
        if (!empty) begin
          // replace-top: old top goes out, new word takes its slot
          dout_d = mem_q[top_idx];
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          dout_d = bus.Data_In;
        end
      end
      2'b10: begin
        if (!full) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end else begin
          ovf_ev = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          dout_d  = mem_q[top_idx];
          count_d = count_q - CW'(1);
          valid_d = 1'b1;
        end else begin
          unf_ev = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  // Storage is not reset; rst still gates writes so an edge during reset
  // cannot land a request.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[wr_idx] <= bus.Data_In;
  end

`ifdef PARAM_STACK_ERR_FLAGS_EN
  logic ovf_q, unf_q;
  logic clr;
  assign clr = bus.CS & bus.Clr_Err;

  // An event on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_ev | (ovf_q & ~clr);
      unf_q <= unf_ev | (unf_q & ~clr);
    end
  end

  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
`else
  logic unused_err;
  assign unused_err    = ^{bus.Clr_Err, ovf_ev, unf_ev};
  assign bus.Overflow  = 1'b0;
  assign bus.Underflow = 1'b0;
`endif

  assign bus.Data_Out    = dout_q;
  assign bus.Valid       = valid_q;
  assign bus.Count       = count_q;
  assign bus.Top         = empty ? '0 : mem_q[top_idx];
  assign bus.Full        = full;
  assign bus.Empty       = empty;
  assign bus.Almost_Full = (count_q >= AF_C);
endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef PARAM_STACK_ERR_FLAGS_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  param_stack_if #(.DATA_WIDTH(8), .ADDR_DEPTH(4)) bus ();

  param_stack #(.DATA_WIDTH(8), .ADDR_DEPTH(4), .ALMOST_FULL_LVL(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic cs, input logic push, input logic pop,
                     input logic [7:0] din, input logic clr);
    bus.CS = cs; bus.Push = push; bus.Pop = pop; bus.Data_In = din; bus.Clr_Err = clr;
  endtask

  // one clock edge, then settle away from it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 8'h00, 0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    drv(1, 1, 0, d, 0);
    cyc();
    drv(0, 0, 0, 8'h00, 0);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp, input logic [4:0] cnt);
    drv(1, 0, 1, 8'h00, 0);
    cyc();
    drv(0, 0, 0, 8'h00, 0);
    chk({tag, "_dout"}, bus.Data_Out, exp);
    chk({tag, "_valid"}, bus.Valid, 1);
    chk({tag, "_count"}, bus.Count, cnt);
  endtask

  initial begin
    drv(0, 0, 0, 8'h00, 0);
    #12;
    // reset state
    chk("rst_count", bus.Count, 0);
    chk("rst_dout", bus.Data_Out, 0);
    chk("rst_valid", bus.Valid, 0);
    chk("rst_empty", bus.Empty, 1);
    chk("rst_top", bus.Top, 0);
    chk("rst_ovf", bus.Overflow, 0);
    rst = 1'b1;
    cyc();

    // push three, pop three
    push(8'h11); push(8'h22); push(8'h33);
    chk("p3_count", bus.Count, 3);
    chk("p3_top", bus.Top, 8'h33);
    chk("p3_valid", bus.Valid, 0);
    pop_chk("pop1", 8'h33, 2);
    pop_chk("pop2", 8'h22, 1);
    pop_chk("pop3", 8'h11, 0);
    cyc();
    chk("idle_valid", bus.Valid, 0);
    chk("idle_empty", bus.Empty, 1);
    chk("idle_dout_hold", bus.Data_Out, 8'h11);

    // fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk($sformatf("fill%0d_af", i), bus.Almost_Full, (i + 1 >= 14) ? 1 : 0);
    end
    chk("full_count", bus.Count, 16);
    chk("full_flag", bus.Full, 1);
    chk("full_top", bus.Top, 8'h0F);
    push(8'hAA);
    chk("ovf_count", bus.Count, 16);
    chk("ovf_top", bus.Top, 8'h0F);
    chk("ovf_flag", bus.Overflow, ERR_ON);
    // replace-top while full is not an overflow; clear first then check
    drv(1, 0, 0, 8'h00, 1); cyc();
    chk("ovf_clr", bus.Overflow, 0);
    drv(1, 1, 1, 8'hBB, 0); cyc();
    chk("rt_full_dout", bus.Data_Out, 8'h0F);
    chk("rt_full_ovf", bus.Overflow, 0);
    chk("rt_full_count", bus.Count, 16);
    pop_chk("pop_full", 8'hBB, 15);
    chk("pop_full_flag", bus.Full, 0);
    chk("pop_full_af", bus.Almost_Full, 1);
    pop_chk("pop_af", 8'h0E, 14);
    pop_chk("pop_af2", 8'h0D, 13);
    chk("af_drop", bus.Almost_Full, 0);

    // replace-top at count 3
    do_reset();
    chk("rst2_count", bus.Count, 0);
    chk("rst2_dout", bus.Data_Out, 0);
    push(8'h11); push(8'h22); push(8'h33);
    drv(1, 1, 1, 8'h99, 0); cyc(); drv(0, 0, 0, 8'h00, 0);
    chk("rt_dout", bus.Data_Out, 8'h33);
    chk("rt_valid", bus.Valid, 1);
    chk("rt_count", bus.Count, 3);
    chk("rt_top", bus.Top, 8'h99);

    // bypass on empty, underflow, clear
    do_reset();
    drv(1, 1, 1, 8'h5A, 0); cyc(); drv(0, 0, 0, 8'h00, 0);
    chk("byp_dout", bus.Data_Out, 8'h5A);
    chk("byp_valid", bus.Valid, 1);
    chk("byp_count", bus.Count, 0);
    chk("byp_unf", bus.Underflow, 0);
    drv(1, 0, 1, 8'h00, 0); cyc(); drv(0, 0, 0, 8'h00, 0);
    chk("unf_valid", bus.Valid, 0);
    chk("unf_flag", bus.Underflow, ERR_ON);
    chk("unf_dout_hold", bus.Data_Out, 8'h5A);
    chk("unf_count", bus.Count, 0);
    drv(0, 0, 0, 8'h00, 1); cyc();
    chk("unf_clr_cs0", bus.Underflow, ERR_ON);
    drv(1, 0, 1, 8'h00, 1); cyc();
    chk("unf_clr_race", bus.Underflow, ERR_ON);
    drv(1, 0, 0, 8'h00, 1); cyc(); drv(0, 0, 0, 8'h00, 0);
    chk("unf_clr", bus.Underflow, 0);

    // async reset mid-cycle
    push(8'h41); push(8'h42); push(8'h43);
    drv(1, 0, 1, 8'h00, 0); cyc(); drv(1, 1, 0, 8'h77, 0);
    chk("pre_rst_count", bus.Count, 2);
    chk("pre_rst_dout", bus.Data_Out, 8'h43);
    rst = 1'b0;
    #2;
    chk("arst_count", bus.Count, 0);
    chk("arst_dout", bus.Data_Out, 0);
    chk("arst_empty", bus.Empty, 1);
    chk("arst_valid", bus.Valid, 0);
    cyc();
    chk("arst_hold_count", bus.Count, 0);
    drv(0, 1, 0, 8'h77, 0);
    rst = 1'b1;
    cyc();
    chk("cs0_count", bus.Count, 0);
    drv(1, 1, 0, 8'h66, 0); cyc(); drv(0, 0, 0, 8'h00, 0);
    chk("post_rst_count", bus.Count, 1);
    chk("post_rst_top", bus.Top, 8'h66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
